driver_bfm: RTL and testbench
=============================

DRIVER_BFM -- requirements
Module: driver_bfm

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 2..65535.
REQ-002 Parameter PARITY_EN, default 0: 1 inserts an even-parity bit after the data bits.
REQ-003 Parameter STOP_BITS, default 1: number of stop bits; legal values 1 or 2.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge system clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 tx_data  input  8  byte to transmit; sampled on acceptance.
REQ-008 tx_valid  input  1  requester has a byte on tx_data.
REQ-009 tx_ready  output  1  driver can accept a byte.
REQ-010 tx  output  1  serial line output, idle high.
REQ-011 busy  output  1  a frame is in progress.
REQ-012 done  output  1  one-cycle pulse at the end of each frame.

Function
REQ-013 The state machine SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-014 tx_ready SHALL be 1 only in IDLE; a byte is accepted on a rising edge where tx_valid and tx_ready are both 1.
REQ-015 On acceptance, tx_data SHALL be latched into a shift register and the state SHALL enter START; tx SHALL go 0 in the next cycle (1-cycle latency).
REQ-016 Each bit SHALL be held on tx for exactly CLKS_PER_BIT cycles, timed by a bit-cycle counter cleared at every bit boundary.
REQ-017 START drives 0; DATA drives bits 0..7, LSB first; PARITY (only if PARITY_EN=1) drives XOR of the 8 latched bits; STOP drives 1 for STOP_BITS bit times.
REQ-018 Transition rules: START->DATA; DATA->DATA until 8 bits are sent; after 8 bits, DATA->PARITY if PARITY_EN=1, else DATA->STOP; PARITY->STOP; STOP->IDLE after the last stop bit.
REQ-019 Frame length SHALL be (10 + PARITY_EN + STOP_BITS - 1) * CLKS_PER_BIT cycles.
REQ-020 done SHALL pulse high for exactly one cycle, in the cycle the machine returns to IDLE; tx_ready SHALL be 1 in that same cycle.
REQ-021 Back-to-back transfers: if tx_valid is held, the next byte SHALL be accepted in the cycle done is high; the next start bit then begins immediately after, with no extra idle bit time.
REQ-022 tx_data and tx_valid changes outside the acceptance cycle SHALL NOT affect the frame in progress.
REQ-023 busy SHALL equal NOT tx_ready.
REQ-024 In IDLE, tx SHALL be 1.

Reset
REQ-025 While rst_n is 0: state=IDLE, tx=1, tx_ready=1, busy=0, done=0, and all counters and the shift register are 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously), with no done pulse.
REQ-027 After reset is released, the first acceptance SHALL be possible on the first rising edge.

Structure
REQ-028 Package driver_bfm_pkg SHALL hold the state enum type and the DATA_BITS=8 constant.
REQ-029 One sub-module, driver_bfm_baud_gen, is natural: a CLKS_PER_BIT counter with a sync clear and a bit_tick output; otherwise the design is a single flat FSM.

Verification
REQ-030 CLKS_PER_BIT=4, PARITY_EN=0: send 0x2A (42) -> tx carries 0,0,1,0,1,0,1,0,0,1, each held 4 cycles; frame is 40 cycles; one done pulse.
REQ-031 PARITY_EN=1: send 0x2A -> parity bit is 1 (three ones); frame is 44 cycles at CLKS_PER_BIT=4.
REQ-032 tx_valid held with 0x55 then 0xA3 -> second start bit immediately follows the first stop bit; exactly two done pulses.
REQ-033 Assert rst_n=0 during DATA bit 3 -> tx=1, tx_ready=1, no done pulse; a new 0x2A frame afterwards is correct.
REQ-034 STOP_BITS=2, CLKS_PER_BIT=16 -> tx stays high for 32 cycles after bit 7 before done; tx_ready=0 throughout the frame.

Source files
------------

// File: rtl/driver_bfm_pkg.sv
// Shared types and constants for the serial driver BFM.
package driver_bfm_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned BIT_IDX_W  = $clog2(DATA_BITS);
    localparam int unsigned BAUD_CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

endpackage

// File: rtl/driver_bfm_baud_gen.sv
// Bit-time counter: counts clocks within one serial bit and flags the last one.
// Ports:
//   clk, rst_n    - clock, async active-low reset
//   i_clear       - synchronous clear (held while the line is idle)
//   o_bit_tick_c  - high in the final clock of each bit time (combinational)
module driver_bfm_baud_gen
    import driver_bfm_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_bit_tick_c
);

    logic [BAUD_CNT_W-1:0] r_cnt;
    logic                  w_tick;

    assign w_tick       = (r_cnt == BAUD_CNT_W'(CLKS_PER_BIT - 1));
    assign o_bit_tick_c = w_tick;

    // Wraps at every bit boundary so each bit starts counting from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + BAUD_CNT_W'(1);
        end
    end

endmodule

// File: rtl/driver_bfm.sv
// Serial frame driver: start bit, 8 data bits LSB first, optional even
// parity, 1 or 2 stop bits. One byte accepted per frame via valid/ready.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   tx_data     - byte to send, latched on acceptance
//   tx_valid    - requester has a byte
//   tx_ready    - driver is idle and can accept
//   tx          - serial line, idle high
//   busy        - frame in progress (inverse of tx_ready)
//   done        - one-cycle pulse on return to idle
module driver_bfm
    import driver_bfm_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   w_shift_nxt;
    logic [BIT_IDX_W-1:0]   r_bit_idx;
    logic [BIT_IDX_W-1:0]   w_bit_idx_nxt;
    logic                   r_stop_idx;
    logic                   w_stop_idx_nxt;
    logic                   r_parity;
    logic                   w_parity_nxt;
    logic                   r_tx;
    logic                   w_tx_nxt;
    logic                   r_tx_ready;
    logic                   r_busy;
    logic                   r_done;
    logic                   w_done_nxt;
    logic                   w_bit_tick;
    logic                   w_baud_clear;

    assign w_baud_clear = (r_state == IDLE);

    driver_bfm_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (w_baud_clear),
        .o_bit_tick_c (w_bit_tick)
    );

    // State and datapath registers; outputs are registered from next-state values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_parity   <= 1'b0;
            r_tx       <= 1'b1;
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_stop_idx <= w_stop_idx_nxt;
            r_parity   <= w_parity_nxt;
            r_tx       <= w_tx_nxt;
            r_tx_ready <= (w_state_nxt == IDLE);
            r_busy     <= (w_state_nxt != IDLE);
            r_done     <= w_done_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bit_idx_nxt  = r_bit_idx;
        w_stop_idx_nxt = r_stop_idx;
        w_parity_nxt   = r_parity;
        w_done_nxt     = 1'b0;
        w_tx_nxt       = 1'b1;

        case (r_state)
            IDLE: begin
                // tx_ready is high exactly in IDLE, so valid alone means acceptance
                if (tx_valid) begin
                    w_shift_nxt   = tx_data;
                    w_parity_nxt  = ^tx_data;
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = START;
                end
            end
            START: begin
                if (w_bit_tick) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_bit_tick) begin
                    w_shift_nxt = {1'b0, r_shift[DATA_BITS-1:1]};
                    if (r_bit_idx == BIT_IDX_W'(DATA_BITS - 1)) begin
                        w_bit_idx_nxt  = '0;
                        w_stop_idx_nxt = 1'b0;
                        w_state_nxt    = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + BIT_IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (w_bit_tick) begin
                    w_stop_idx_nxt = 1'b0;
                    w_state_nxt    = STOP;
                end
            end
            STOP: begin
                if (w_bit_tick) begin
                    if (r_stop_idx == 1'(STOP_BITS - 1)) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_stop_idx_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Line level follows the state being entered so tx lags acceptance by one cycle.
        case (w_state_nxt)
            START:   w_tx_nxt = 1'b0;
            DATA:    w_tx_nxt = w_shift_nxt[0];
            PARITY:  w_tx_nxt = w_parity_nxt;
            default: w_tx_nxt = 1'b1;
        endcase
    end

    assign tx       = r_tx;
    assign tx_ready = r_tx_ready;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_driver_bfm.sv
// Self-checking bench: three driver instances (plain, parity, two stop bits)
// checked cycle by cycle against an expected bit list built from the frame rules.
module tb_driver_bfm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data  [3];
    logic       tx_valid [3];
    logic       tx_ready [3];
    logic       tx       [3];
    logic       busy     [3];
    logic       done     [3];

    int unsigned done_cnt [3] = '{0, 0, 0};
    int unsigned busy_cyc [3] = '{0, 0, 0};
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    driver_bfm #(.CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .tx(tx[0]), .busy(busy[0]), .done(done[0]));

    driver_bfm #(.CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .tx(tx[1]), .busy(busy[1]), .done(done[1]));

    driver_bfm #(.CLKS_PER_BIT(16), .PARITY_EN(0), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready[2]), .tx(tx[2]), .busy(busy[2]), .done(done[2]));

    // Count done pulses and busy cycles per instance.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (done[k] === 1'b1) done_cnt[k]++;
            if (busy[k] === 1'b1) busy_cyc[k]++;
        end
    end

    function automatic int cpb_of(input int k);
        return (k == 2) ? 16 : 4;
    endfunction

    function automatic int pen_of(input int k);
        return (k == 1) ? 1 : 0;
    endfunction

    function automatic int sb_of(input int k);
        return (k == 2) ? 2 : 1;
    endfunction

    // Called at a negedge while idle: check idle outputs, present a byte.
    task automatic begin_frame(input int k, input logic [7:0] d);
        n_tests++;
        if ({tx[k], tx_ready[k], busy[k], done[k]} !== 4'b1100) begin
            n_fail++;
            $display("FAIL idle_before_frame dut%0d: {tx,ready,busy,done}=%b expected 1100",
                     k, {tx[k], tx_ready[k], busy[k], done[k]});
        end
        tx_data[k]  = d;
        tx_valid[k] = 1'b1;
    endtask

    // Byte d is already presented; follow the frame, end at the done-cycle negedge.
    task automatic run_frame(input int k, input logic [7:0] d, input bit chain,
                             input logic [7:0] nd);
        bit          exp_q[$];
        int          exp_len;
        int unsigned b0;
        logic [3:0]  obs;
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        if (pen_of(k) != 0) exp_q.push_back(^d);
        for (int s = 0; s < sb_of(k); s++) exp_q.push_back(1'b1);
        exp_len = (10 + pen_of(k) + sb_of(k) - 1) * cpb_of(k);
        b0 = busy_cyc[k];
        @(posedge clk);
        @(negedge clk);
        foreach (exp_q[i]) begin
            for (int c = 0; c < cpb_of(k); c++) begin
                tx_valid[k] = 1'($urandom);
                tx_data[k]  = 8'($urandom);
                obs = {tx[k], tx_ready[k], busy[k], done[k]};
                n_tests++;
                if (obs !== {exp_q[i], 3'b010}) begin
                    n_fail++;
                    $display("FAIL frame dut%0d byte %h bit%0d cyc%0d: {tx,ready,busy,done}=%b expected %b",
                             k, d, i, c, obs, {exp_q[i], 3'b010});
                end
                @(negedge clk);
            end
        end
        obs = {tx[k], tx_ready[k], busy[k], done[k]};
        n_tests++;
        if (obs !== 4'b1101) begin
            n_fail++;
            $display("FAIL done_cycle dut%0d: {tx,ready,busy,done}=%b expected 1101", k, obs);
        end
        n_tests++;
        if (int'(busy_cyc[k] - b0) != exp_len) begin
            n_fail++;
            $display("FAIL frame_length dut%0d: %0d cycles expected %0d",
                     k, busy_cyc[k] - b0, exp_len);
        end
        tx_valid[k] = chain;
        tx_data[k]  = chain ? nd : 8'($urandom);
    endtask

    // One cycle after a lone frame: done must have dropped, line idle.
    task automatic check_after(input int k, input int unsigned dc0, input int unsigned n_done);
        @(negedge clk);
        n_tests++;
        if ({tx[k], tx_ready[k], busy[k], done[k]} !== 4'b1100) begin
            n_fail++;
            $display("FAIL post_frame dut%0d: {tx,ready,busy,done}=%b expected 1100",
                     k, {tx[k], tx_ready[k], busy[k], done[k]});
        end
        n_tests++;
        if (done_cnt[k] - dc0 != n_done) begin
            n_fail++;
            $display("FAIL done_count dut%0d: %0d pulses expected %0d", k, done_cnt[k] - dc0, n_done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tx_valid[k] = 1'b0;
            tx_data[k]  = 8'h00;
        end
        #12;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if ({tx[k], tx_ready[k], busy[k], done[k]} !== 4'b1100) begin
                n_fail++;
                $display("FAIL reset dut%0d: {tx,ready,busy,done}=%b expected 1100",
                         k, {tx[k], tx_ready[k], busy[k], done[k]});
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single(input int k, input logic [7:0] d);
        int unsigned dc0;
        dc0 = done_cnt[k];
        begin_frame(k, d);
        run_frame(k, d, 1'b0, 8'h00);
        check_after(k, dc0, 1);
    endtask

    task automatic test_back_to_back();
        int unsigned dc0;
        dc0 = done_cnt[0];
        @(negedge clk);
        begin_frame(0, 8'h55);
        run_frame(0, 8'h55, 1'b1, 8'hA3);
        run_frame(0, 8'hA3, 1'b0, 8'h00);
        check_after(0, dc0, 2);
    endtask

    task automatic test_reset_mid_frame();
        int unsigned dc0;
        dc0 = done_cnt[0];
        @(negedge clk);
        begin_frame(0, 8'h2A);
        @(posedge clk);
        repeat (18) @(negedge clk);
        tx_valid[0] = 1'b0;
        n_tests++;
        if (busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_frame_busy: busy=%b expected 1", busy[0]);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({tx[0], tx_ready[0], busy[0], done[0]} !== 4'b1100) begin
            n_fail++;
            $display("FAIL async_abort: {tx,ready,busy,done}=%b expected 1100",
                     {tx[0], tx_ready[0], busy[0], done[0]});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n_tests++;
        if (done_cnt[0] != dc0) begin
            n_fail++;
            $display("FAIL abort_no_done: %0d pulses expected 0", done_cnt[0] - dc0);
        end
        // First acceptance on the first rising edge after release.
        test_single(0, 8'h2A);
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int          k;
            int unsigned dc0;
            logic [7:0]  d;
            logic [7:0]  nd;
            bit          chain;
            k     = int'($urandom_range(0, 2));
            d     = 8'($urandom);
            nd    = 8'($urandom);
            chain = 1'($urandom);
            dc0   = done_cnt[k];
            @(negedge clk);
            begin_frame(k, d);
            run_frame(k, d, chain, nd);
            if (chain) run_frame(k, nd, 1'b0, 8'h00);
            check_after(k, dc0, chain ? 2 : 1);
        end
    endtask

    initial begin
        test_reset();
        test_single(0, 8'h2A);
        @(negedge clk);
        test_single(1, 8'h2A);
        test_back_to_back();
        test_reset_mid_frame();
        @(negedge clk);
        test_single(2, 8'($urandom));
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
